// File: rtl/exec_mem_wb_backend_pkg.sv
// Shared encodings for the execute/memory/write-back backend:
// ALU opcodes, write-back selects and the bit positions of the
// MEM/EX/WB control fields coming out of decode.
package exec_mem_wb_backend_pkg;

    // Shift amount is always taken from the low four bits of B.
    localparam int SHW = 4;

    typedef enum logic [3:0] {
        ALU_PASS_A = 4'd0,
        ALU_ADD    = 4'd1,
        ALU_SUB    = 4'd2,
        ALU_AND    = 4'd3,
        ALU_OR     = 4'd4,
        ALU_NOT    = 4'd5,
        ALU_SHL    = 4'd6,
        ALU_SHR    = 4'd7,
        ALU_PASS_B = 4'd8
    } alu_op_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_IMM = 2'd2,
        WB_SRC = 2'd3
    } wb_sel_e;

    // MEM_signals fields
    localparam int MEM_RD       = 3;
    localparam int MEM_WR       = 2;
    localparam int MEM_ADDR_ALU = 1;
    localparam int MEM_DATA_SRC = 0;

    // EX_signals fields
    localparam int EX_OP_HI    = 5;
    localparam int EX_OP_LO    = 2;
    localparam int EX_ALU_EN   = 1;
    localparam int EX_SHAM_SEL = 0;

    // WB_signals fields
    localparam int WB_REGWR  = 2;
    localparam int WB_SEL_HI = 1;
    localparam int WB_SEL_LO = 0;

endpackage

// File: rtl/exec_mem_wb_backend_if.sv
// Decode-to-backend bundle plus the register-file write-back path.
// master = decode side, slave = backend.
interface exec_mem_wb_backend_if #(parameter int W = 16);
    logic         in_valid;
    logic         flush;
    logic [3:0]   MEM_signals;
    logic [5:0]   EX_signals;
    logic [2:0]   WB_signals;
    logic [W-1:0] Rsrc;
    logic [W-1:0] Rdst;
    logic [3:0]   shamt;
    logic [W-1:0] Imm;
    logic [2:0]   dst_addr;
    logic         regWrite;
    logic [W-1:0] WD;
    logic [2:0]   WA;

    modport master (
        output in_valid, flush, MEM_signals, EX_signals, WB_signals,
               Rsrc, Rdst, shamt, Imm, dst_addr,
        input  regWrite, WD, WA
    );

    modport slave (
        input  in_valid, flush, MEM_signals, EX_signals, WB_signals,
               Rsrc, Rdst, shamt, Imm, dst_addr,
        output regWrite, WD, WA
    );
endinterface

// File: rtl/exec_mem_wb_backend_alu.sv
// Combinational backend ALU. Flag outputs exist only when
// BACKEND_FLAGS_EN is defined.
module backend_alu
    import exec_mem_wb_backend_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [3:0]   op_i,
    input  logic         en_i,
    output logic [W-1:0] result_o
`ifdef BACKEND_FLAGS_EN
   ,output logic         zf_o,
    output logic         nf_o,
    output logic         cf_o
`endif
);
    logic [SHW-1:0] sh;
    assign sh = b_i[SHW-1:0];

    // Result select; disabled ALU and unused opcodes pass A through.
    always_comb begin
        result_o = a_i;
        if (en_i) begin
            case (alu_op_e'(op_i))
                ALU_ADD:    result_o = a_i + b_i;
                ALU_SUB:    result_o = a_i - b_i;
                ALU_AND:    result_o = a_i & b_i;
                ALU_OR:     result_o = a_i | b_i;
                ALU_NOT:    result_o = ~a_i;
                ALU_SHL:    result_o = a_i << sh;
                ALU_SHR:    result_o = a_i >> sh;
                ALU_PASS_B: result_o = b_i;
                default:    result_o = a_i;
            endcase
        end
    end

`ifdef BACKEND_FLAGS_EN
    logic [W:0] add_ext, sub_ext, shl_ext, shr_ext;

    // Carry: add carry-out, subtract borrow, last bit shifted out
    // (the extension bit stays 0 for a zero shift).
    always_comb begin
        add_ext = {1'b0, a_i} + {1'b0, b_i};
        sub_ext = {1'b0, a_i} - {1'b0, b_i};
        shl_ext = {1'b0, a_i} << sh;
        shr_ext = {a_i, 1'b0} >> sh;
        zf_o    = (result_o == '0);
        nf_o    = result_o[W-1];
        case (alu_op_e'(op_i))
            ALU_ADD: cf_o = add_ext[W];
            ALU_SUB: cf_o = sub_ext[W];
            ALU_SHL: cf_o = shl_ext[W];
            ALU_SHR: cf_o = shr_ext[0];
            default: cf_o = 1'b0;
        endcase
    end
`endif
endmodule

// File: rtl/exec_mem_wb_backend_buffer.sv
// Generic pipeline register: synchronous active-high clear to zero.
module Buffer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    // Capture every cycle; reset empties the stage.
    always_ff @(posedge clk) begin
        if (rst) q_o <= '0;
        else     q_o <= d_i;
    end
endmodule

// File: rtl/exec_mem_wb_backend.sv
// Execute / memory / write-back half of the pipeline.
// E/M and M/W registers, data memory, write-back mux.
// Optional macro BACKEND_FLAGS_EN adds the {Z,N,C} flags output.
module exec_mem_wb_backend
    import exec_mem_wb_backend_pkg::*;
#(
    parameter int W         = 16,
    parameter int MEM_DEPTH = 256,
    parameter int MEM_AW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    exec_mem_wb_backend_if.slave  bus
`ifdef BACKEND_FLAGS_EN
   ,output logic [2:0]            flags
`endif
);
    typedef struct packed {
        logic         valid;
        logic [3:0]   mem;
        logic [2:0]   wb;
        logic [W-1:0] alu;
        logic [W-1:0] rsrc;
        logic [W-1:0] rdst;
        logic [W-1:0] imm;
        logic [2:0]   dst;
    } em_t;

    typedef struct packed {
        logic         valid;
        logic [2:0]   wb;
        logic [W-1:0] alu;
        logic [W-1:0] mdata;
        logic [W-1:0] imm;
        logic [W-1:0] rsrc;
        logic [2:0]   dst;
    } mw_t;

    em_t em_d, em_q;
    mw_t mw_d, mw_q;

    logic [W-1:0]      alu_b, alu_res;
    logic              in_ok;
    logic [MEM_AW-1:0] mem_addr;
    logic [W-1:0]      mem_wdata, mem_rdata;
    logic [W-1:0]      dmem [MEM_DEPTH];

    // ---------------- Execute ----------------
    assign alu_b = bus.EX_signals[EX_SHAM_SEL] ? bus.Rdst
                                               : {{(W-SHW){1'b0}}, bus.shamt};
    assign in_ok = bus.in_valid & ~bus.flush;

`ifdef BACKEND_FLAGS_EN
    logic       zf, nf, cf;
    logic [2:0] flags_q;
`endif

    backend_alu #(.W(W)) u_alu (
        .a_i      (bus.Rsrc),
        .b_i      (alu_b),
        .op_i     (bus.EX_signals[EX_OP_HI:EX_OP_LO]),
        .en_i     (bus.EX_signals[EX_ALU_EN]),
        .result_o (alu_res)
`ifdef BACKEND_FLAGS_EN
       ,.zf_o     (zf),
        .nf_o     (nf),
        .cf_o     (cf)
`endif
    );

    // Bubbles keep their payload but may never write memory or registers.
    always_comb begin
        em_d       = '0;
        em_d.valid = in_ok;
        em_d.mem   = bus.MEM_signals;
        em_d.wb    = bus.WB_signals;
        if (!in_ok) begin
            em_d.mem[MEM_RD]  = 1'b0;
            em_d.mem[MEM_WR]  = 1'b0;
            em_d.wb[WB_REGWR] = 1'b0;
        end
        em_d.alu  = alu_res;
        em_d.rsrc = bus.Rsrc;
        em_d.rdst = bus.Rdst;
        em_d.imm  = bus.Imm;
        em_d.dst  = bus.dst_addr;
    end

    Buffer #(.WIDTH($bits(em_t))) u_em (
        .clk (clk), .rst (rst), .d_i (em_d), .q_o (em_q)
    );

`ifdef BACKEND_FLAGS_EN
    // Flags follow only valid, ALU-enabled instructions.
    always_ff @(posedge clk) begin
        if (rst)
            flags_q <= 3'b000;
        else if (in_ok && bus.EX_signals[EX_ALU_EN])
            flags_q <= {zf, nf, cf};
    end
    assign flags = flags_q;
`endif

    // ---------------- Memory ----------------
    assign mem_addr  = em_q.mem[MEM_ADDR_ALU] ? em_q.alu[MEM_AW-1:0]
                                              : em_q.rsrc[MEM_AW-1:0];
    assign mem_wdata = em_q.mem[MEM_DATA_SRC] ? em_q.rsrc : em_q.rdst;
    // Asynchronous read sampled into M/W on the same edge as the write,
    // so a combined read/write returns the old word.
    assign mem_rdata = dmem[mem_addr];

    // Data memory write port; contents survive reset, writes during reset are dropped.
    always_ff @(posedge clk) begin
        if (!rst && em_q.mem[MEM_WR])
            dmem[mem_addr] <= mem_wdata;
    end

    // M/W payload; memory data is zero unless the instruction reads.
    always_comb begin
        mw_d       = '0;
        mw_d.valid = em_q.valid;
        mw_d.wb    = em_q.wb;
        mw_d.alu   = em_q.alu;
        mw_d.mdata = em_q.mem[MEM_RD] ? mem_rdata : '0;
        mw_d.imm   = em_q.imm;
        mw_d.rsrc  = em_q.rsrc;
        mw_d.dst   = em_q.dst;
    end

    Buffer #(.WIDTH($bits(mw_t))) u_mw (
        .clk (clk), .rst (rst), .d_i (mw_d), .q_o (mw_q)
    );

    // ---------------- Write-back ----------------
    // Write data select; WD/WA always reflect M/W even without regWrite.
    always_comb begin
        case (wb_sel_e'(mw_q.wb[WB_SEL_HI:WB_SEL_LO]))
            WB_ALU:  bus.WD = mw_q.alu;
            WB_MEM:  bus.WD = mw_q.mdata;
            WB_IMM:  bus.WD = mw_q.imm;
            default: bus.WD = mw_q.rsrc;
        endcase
    end

    assign bus.regWrite = mw_q.valid & mw_q.wb[WB_REGWR];
    assign bus.WA       = mw_q.dst;
endmodule

// File: tb/tb_exec_mem_wb_backend.sv
// Directed self-checking bench for exec_mem_wb_backend.
// Define BACKEND_FLAGS_EN to also exercise the flags output.
module tb_exec_mem_wb_backend;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    exec_mem_wb_backend_if #(.W(16)) bus ();
`ifdef BACKEND_FLAGS_EN
    logic [2:0] flags;
`endif

    exec_mem_wb_backend #(.W(16), .MEM_DEPTH(256), .MEM_AW(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus)
`ifdef BACKEND_FLAGS_EN
       ,.flags (flags)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic fl, input logic [3:0] mem,
                         input logic [5:0] ex, input logic [2:0] wb,
                         input logic [15:0] rsrc, input logic [15:0] rdst,
                         input logic [3:0] sh, input logic [15:0] imm,
                         input logic [2:0] dst);
        bus.in_valid    = v;
        bus.flush       = fl;
        bus.MEM_signals = mem;
        bus.EX_signals  = ex;
        bus.WB_signals  = wb;
        bus.Rsrc        = rsrc;
        bus.Rdst        = rdst;
        bus.shamt       = sh;
        bus.Imm         = imm;
        bus.dst_addr    = dst;
    endtask

    task automatic bubble();
        drive(1'b0, 1'b0, 4'h0, 6'h0, 3'h0, 16'h0, 16'h0, 4'h0, 16'h0, 3'h0);
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic rw, input logic [15:0] wd,
                          input logic [2:0] wa);
        chk({tag, ".regWrite"}, {15'd0, bus.regWrite}, {15'd0, rw});
        if (rw) begin
            chk({tag, ".WD"}, bus.WD, wd);
            chk({tag, ".WA"}, {13'd0, bus.WA}, {13'd0, wa});
        end
    endtask

    // EX = {ALUop, ALU enable, shamSel}; WB = {regWrite, WBsel};
    // MEM = {memRead, memWrite, memAddress, memData}
    initial begin
        bubble();
        rst = 1'b1;
        tick();
        tick();
        chk("reset.regWrite", {15'd0, bus.regWrite}, 16'h0000);
        chk("reset.WD", bus.WD, 16'h0000);
        chk("reset.WA", {13'd0, bus.WA}, 16'h0000);
`ifdef BACKEND_FLAGS_EN
        chk("reset.flags", {13'd0, flags}, 16'h0000);
`endif

        // ADD then reset at the following edge: never writes back
        rst = 1'b0;
        drive(1, 0, 4'b0000, {4'd1, 1'b1, 1'b1}, 3'b100, 16'h0003, 16'h0004, 4'd0, 16'h0, 3'd5);
        tick();
        rst = 1'b1;
        bubble();
        tick();
        chk("midrst.regWrite", {15'd0, bus.regWrite}, 16'h0000);
        chk("midrst.WD", bus.WD, 16'h0000);
        chk("midrst.WA", {13'd0, bus.WA}, 16'h0000);
        rst = 1'b0;
        tick();
        chk("midrst.after", {15'd0, bus.regWrite}, 16'h0000);

        // ADD 3+4 -> 7 into r5
        drive(1, 0, 4'b0000, {4'd1, 1'b1, 1'b1}, 3'b100, 16'h0003, 16'h0004, 4'd0, 16'h0, 3'd5);
        tick();
        bubble();
        tick();
        chk_wb("add", 1'b1, 16'h0007, 3'd5);

        // SHL 0x00F1 << 4 -> 0x0F10
        drive(1, 0, 4'b0000, {4'd6, 1'b1, 1'b0}, 3'b100, 16'h00F1, 16'h0000, 4'd4, 16'h0, 3'd2);
        tick();
`ifdef BACKEND_FLAGS_EN
        chk("shl.flags", {13'd0, flags}, 16'h0000);
`endif
        // ADD 0xFFFF + 1 -> 0, Z and C set
        drive(1, 0, 4'b0000, {4'd1, 1'b1, 1'b1}, 3'b100, 16'hFFFF, 16'h0001, 4'd0, 16'h0, 3'd1);
        tick();
        chk_wb("shl", 1'b1, 16'h0F10, 3'd2);
`ifdef BACKEND_FLAGS_EN
        chk("addc.flags", {13'd0, flags}, 16'h0005);
`endif
        // SUB 3-4 -> 0xFFFF, N and borrow
        drive(1, 0, 4'b0000, {4'd2, 1'b1, 1'b1}, 3'b100, 16'h0003, 16'h0004, 4'd0, 16'h0, 3'd3);
        tick();
        chk_wb("addc", 1'b1, 16'h0000, 3'd1);
`ifdef BACKEND_FLAGS_EN
        chk("sub.flags", {13'd0, flags}, 16'h0003);
`endif
        // PASS_B of shamt 9
        drive(1, 0, 4'b0000, {4'd8, 1'b1, 1'b0}, 3'b100, 16'h1234, 16'h0000, 4'd9, 16'h0, 3'd4);
        tick();
        chk_wb("sub", 1'b1, 16'hFFFF, 3'd3);
`ifdef BACKEND_FLAGS_EN
        chk("passb.flags", {13'd0, flags}, 16'h0000);
`endif
        // SHR 0x8001 >> 1 -> 0x4000, last bit out = 1
        drive(1, 0, 4'b0000, {4'd7, 1'b1, 1'b0}, 3'b100, 16'h8001, 16'h0000, 4'd1, 16'h0, 3'd6);
        tick();
        chk_wb("passb", 1'b1, 16'h0009, 3'd4);
`ifdef BACKEND_FLAGS_EN
        chk("shr.flags", {13'd0, flags}, 16'h0001);
`endif
        // Invalid ALU op must not touch flags or write back
        drive(0, 0, 4'b0000, {4'd1, 1'b1, 1'b1}, 3'b100, 16'hFFFF, 16'h0001, 4'd0, 16'h0, 3'd7);
        tick();
        chk_wb("shr", 1'b1, 16'h4000, 3'd6);
`ifdef BACKEND_FLAGS_EN
        chk("bubble.flags", {13'd0, flags}, 16'h0001);
`endif
        bubble();
        tick();
        chk("bubble.regWrite", {15'd0, bus.regWrite}, 16'h0000);

        // Store 0xBEEF to 0x10, then load from 0x0110 (wraps to 0x10)
        drive(1, 0, 4'b0100, 6'h00, 3'b000, 16'h0010, 16'hBEEF, 4'd0, 16'h0, 3'd0);
        tick();
        drive(1, 0, 4'b1000, 6'h00, 3'b101, 16'h0110, 16'h0000, 4'd0, 16'h0, 3'd3);
        tick();
        chk("store.regWrite", {15'd0, bus.regWrite}, 16'h0000);
        bubble();
        tick();
        chk_wb("load", 1'b1, 16'hBEEF, 3'd3);

        // 0x1234 into 0x20, then read+write 0x5555, then read back
        drive(1, 0, 4'b0100, 6'h00, 3'b000, 16'h0020, 16'h1234, 4'd0, 16'h0, 3'd0);
        tick();
        drive(1, 0, 4'b1100, 6'h00, 3'b101, 16'h0020, 16'h5555, 4'd0, 16'h0, 3'd4);
        tick();
        drive(1, 0, 4'b1000, 6'h00, 3'b101, 16'h0020, 16'h0000, 4'd0, 16'h0, 3'd6);
        tick();
        chk_wb("rmw.old", 1'b1, 16'h1234, 3'd4);
        // Load through ALU-computed address 0x011F+1 -> 0x20
        drive(1, 0, 4'b1010, {4'd1, 1'b1, 1'b1}, 3'b101, 16'h011F, 16'h0001, 4'd0, 16'h0, 3'd7);
        tick();
        chk_wb("rmw.new", 1'b1, 16'h5555, 3'd6);
        bubble();
        tick();
        chk_wb("aluaddr", 1'b1, 16'h5555, 3'd7);

        // Flush sandwiched between two good instructions
        drive(1, 0, 4'b0000, 6'h00, 3'b110, 16'h0000, 16'h0000, 4'd0, 16'hAAAA, 3'd1);
        tick();
        drive(1, 1, 4'b0000, 6'h00, 3'b110, 16'h0000, 16'h0000, 4'd0, 16'hBBBB, 3'd2);
        tick();
        chk_wb("flush.prev", 1'b1, 16'hAAAA, 3'd1);
        drive(1, 0, 4'b0000, 6'h00, 3'b111, 16'hCCCC, 16'h0000, 4'd0, 16'h0, 3'd3);
        tick();
        chk("flush.killed", {15'd0, bus.regWrite}, 16'h0000);
        bubble();
        tick();
        chk_wb("flush.next", 1'b1, 16'hCCCC, 3'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
